// File: rtl/vram_arbiter.sv
// Three-way arbiter for the shared single-port video memory: scanout has fixed
// priority, CPU and drawing accelerator alternate, accelerator progress gated via g_ce.
module vram_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        s_req,
    input  logic [17:0] s_a,
    output logic [7:0]  s_i,
    output logic        s_ack,
    input  logic        c_req,
    input  logic [17:0] c_a,
    input  logic [7:0]  c_o,
    input  logic        c_w,
    output logic [7:0]  c_i,
    output logic        c_ack,
    input  logic [17:0] g_a,
    input  logic [7:0]  g_o,
    input  logic        g_w,
    input  logic        g_bsy,
    output logic [7:0]  g_i,
    output logic        g_ce,
    output logic [17:0] m_a,
    output logic [7:0]  m_o,
    output logic        m_w,
    input  logic [7:0]  m_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SCAN = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_ACC  = 2'd3
    } owner_t;

    typedef enum logic {
        LAST_CPU = 1'b0,
        LAST_ACC = 1'b1
    } last_t;

    // registered state
    logic        s_pend_q, c_pend_q, g_pend_q;
    last_t       last_q;
    owner_t      issue_tag_q, exec_tag_q, ack_tag_q;
    logic [17:0] ma_q;
    logic [7:0]  mo_q;
    logic        mw_q;
    logic [7:0]  s_dat_q, c_dat_q, g_dat_q;
    logic        bsy_q;

    // next-state values
    logic        s_pend_d, c_pend_d, g_pend_d;
    last_t       last_d;
    owner_t      issue_tag_d, exec_tag_d, ack_tag_d;
    logic [17:0] ma_d;
    logic [7:0]  mo_d;
    logic        mw_d;
    logic [7:0]  s_dat_d, c_dat_d, g_dat_d;
    logic        bsy_d;

    owner_t      grant;
    logic        s_elig, c_elig, g_elig;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_pend_q    <= 1'b0;
            c_pend_q    <= 1'b0;
            g_pend_q    <= 1'b0;
            last_q      <= LAST_ACC;
            issue_tag_q <= OWN_NONE;
            exec_tag_q  <= OWN_NONE;
            ack_tag_q   <= OWN_NONE;
            ma_q        <= '0;
            mo_q        <= '0;
            mw_q        <= 1'b0;
            s_dat_q     <= '0;
            c_dat_q     <= '0;
            g_dat_q     <= '0;
            bsy_q       <= 1'b0;
        end else begin
            s_pend_q    <= s_pend_d;
            c_pend_q    <= c_pend_d;
            g_pend_q    <= g_pend_d;
            last_q      <= last_d;
            issue_tag_q <= issue_tag_d;
            exec_tag_q  <= exec_tag_d;
            ack_tag_q   <= ack_tag_d;
            ma_q        <= ma_d;
            mo_q        <= mo_d;
            mw_q        <= mw_d;
            s_dat_q     <= s_dat_d;
            c_dat_q     <= c_dat_d;
            g_dat_q     <= g_dat_d;
            bsy_q       <= bsy_d;
        end
    end

    always_comb begin
        s_elig = s_req && !s_pend_q;
        c_elig = c_req && !c_pend_q;
        g_elig = g_bsy && !g_pend_q;

        grant  = OWN_NONE;
        last_d = last_q;
        if (s_elig) begin
            grant = OWN_SCAN;
        end else if (c_elig && g_elig) begin
            // contested slot goes to whoever did not win the last contest
            if (last_q == LAST_ACC) begin
                grant  = OWN_CPU;
                last_d = LAST_CPU;
            end else begin
                grant  = OWN_ACC;
                last_d = LAST_ACC;
            end
        end else if (c_elig) begin
            grant = OWN_CPU;
        end else if (g_elig) begin
            grant = OWN_ACC;
        end

        ma_d = ma_q;
        mo_d = mo_q;
        mw_d = 1'b0;
        case (grant)
            OWN_SCAN: begin
                ma_d = s_a;
            end
            OWN_CPU: begin
                ma_d = c_a;
                mo_d = c_o;
                mw_d = c_w;
            end
            OWN_ACC: begin
                ma_d = g_a;
                mo_d = g_o;
                mw_d = g_w;
            end
            default: ;
        endcase

        // pend drops on the edge that ends the ack cycle, blocking a re-grant on that edge
        s_pend_d = (s_pend_q && (ack_tag_q != OWN_SCAN)) || (grant == OWN_SCAN);
        c_pend_d = (c_pend_q && (ack_tag_q != OWN_CPU))  || (grant == OWN_CPU);
        g_pend_d = (g_pend_q && (ack_tag_q != OWN_ACC))  || (grant == OWN_ACC);

        issue_tag_d = grant;
        exec_tag_d  = issue_tag_q;
        ack_tag_d   = exec_tag_q;

        s_dat_d = s_dat_q;
        c_dat_d = c_dat_q;
        g_dat_d = g_dat_q;
        case (exec_tag_q)
            OWN_SCAN: s_dat_d = m_i;
            OWN_CPU:  c_dat_d = m_i;
            OWN_ACC:  g_dat_d = m_i;
            default: ;
        endcase

        bsy_d = g_bsy;
    end

    always_comb begin
        m_a   = ma_q;
        m_o   = mo_q;
        m_w   = mw_q;
        s_i   = s_dat_q;
        c_i   = c_dat_q;
        g_i   = g_dat_q;
        s_ack = (ack_tag_q == OWN_SCAN);
        c_ack = (ack_tag_q == OWN_CPU);
        // free-running while idle, one pulse per completed access while busy
        g_ce  = !bsy_q || (ack_tag_q == OWN_ACC);
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Three-way arbiter for the shared 256K video memory. It serves the scanout reader, the CPU port and the drawing accelerator, whose address/data/write outputs it consumes and whose progress it gates through a clock enable. Scanout has fixed top priority. CPU and accelerator alternate round-robin. Sits between the requesters and the single-port synchronous VRAM.

## Interface
- No parameters; address width fixed at 18, data width at 8.
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_req  in  1  scanout read request, held until s_ack
- s_a  in  18  scanout address
- s_i  out  8  scanout read data, valid while s_ack=1
- s_ack  out  1  one-cycle completion pulse
- c_req  in  1  CPU request, held until c_ack
- c_a  in  18  CPU address
- c_o  in  8  CPU write data
- c_w  in  1  CPU write strobe, qualifies c_req
- c_i  out  8  CPU read data, valid while c_ack=1
- c_ack  out  1  one-cycle completion pulse
- g_a  in  18  accelerator address
- g_o  in  8  accelerator write data
- g_w  in  1  accelerator write strobe
- g_bsy  in  1  accelerator busy
- g_i  out  8  accelerator read data, held stable between updates
- g_ce  out  1  accelerator clock enable
- m_a  out  18  VRAM address, registered
- m_o  out  8  VRAM write data, registered
- m_w  out  1  VRAM write enable, registered
- m_i  in  8  VRAM read data

## Operation
- VRAM contract: the value registered onto m_a/m_w/m_o at edge k is executed at edge k+1. Read data m_i is stable during the cycle after k+1.
- Issue stage, evaluated every edge. At most one transaction is issued per edge.
  - Candidates: scanout if s_req and not s_pend; CPU if c_req and not c_pend; accelerator if g_bsy and not g_pend.
  - Scanout always wins.
  - Otherwise, if both CPU and accelerator are eligible, the one not named by the `last` flag wins, and `last` is updated to the winner. A lone eligible requester wins without touching `last`.
- On issue: m_a gets the winner's address and m_o its data. m_w gets c_w or g_w (always 0 for scanout). The winner's pend flag is set and its 2-bit owner tag enters the pipeline.
- With no issue: m_w=0; m_a and m_o hold their previous values.
- Owner tag pipeline: stage1 at edge k+1, stage2 at edge k+2.
- At edge k+2 the arbiter captures m_i into the owner's data register (s_i, c_i or g_i) and raises that owner's ack (or g_ce) for exactly one cycle. Capture happens for writes too; captured data is don't-care.
- The pend flag clears on the edge that ends the ack cycle. The requester therefore cannot be re-granted on that edge, which gives it one cycle to drop or change req.
- Accelerator gating:
  - g_bsy=0: g_ce=1 constantly and no accelerator traffic is issued, so command acceptance runs freely.
  - g_bsy=1: g_ce is 1 only in the ack cycle of an accelerator transaction, so the accelerator advances exactly one step per completed access.
  - g_i is the data for the address it held.
  - g_w is written exactly once, because the accelerator holds its outputs while g_ce=0.
- g_bsy falling while g_pend=1: the transaction completes normally and ce is pulsed. This pulse coincides with the free-running ce.

## Timing
- Reset (asynchronous): m_a=0, m_o=0, m_w=0, s_ack=0, c_ack=0, s_i=0, c_i=0, g_i=0, g_ce=1, all pend flags 0, tags invalid, last=accelerator (CPU favoured first).
- Reset mid-transaction: outstanding transactions are dropped with no ack. Release resumes from the idle state.
- Latency, request high at edge k with bus free: ack in the cycle after edge k+2, i.e. 3 cycles from request sample to ack high.
- Per-requester throughput: one transaction per 4 cycles (issue, exec, capture/ack, pend clear).
- Aggregate throughput: one issue per cycle when multiple requesters interleave.
- Simultaneous ack pulses for different requesters cannot occur; at most one tag reaches stage2 per edge.
- Scanout requesting every cycle it is eligible still leaves 3 of every 4 slots for the others. The arbiter provides no further starvation guard.

## Test plan
- Reset then scanout read of s_a=18'h00100 with VRAM[100h]=8'h5A -> m_a=00100h after the first edge; s_ack for one cycle two edges later with s_i=8'h5A; no second issue while s_req is held through the ack cycle.
- CPU write of c_a=18'h20000, c_o=8'h01 -> m_w=1 for exactly one cycle with m_a=20000h; c_ack after 2 edges; a follow-up CPU read of 20000h returns c_i=8'h01.
- CPU and scanout raise req on the same edge -> scanout is issued first; CPU is issued on the next edge; acks arrive on consecutive cycles.
- Accelerator busy drawing (g_w=1 per step) plus a continuous CPU read stream -> issues alternate CPU/accelerator; each g_ce pulse lasts 1 cycle; each accelerator pixel is written exactly once; the VRAM pixel count equals the g_ce pulse count while busy.
- g_bsy=0 -> g_ce=1 every cycle and no accelerator issue. g_bsy rises -> g_ce drops the next cycle and pulses 3 cycles after the first accelerator issue.
- Assert reset_n=0 in the cycle after a CPU issue -> outputs go to reset values immediately; no c_ack appears after release; CPU req re-sampled -> normal 3-cycle completion.
